// File: rtl/sel1to4_demux_buf.sv
// 1-to-4 demultiplexer with a one-entry valid/ready output register per lane.
// The target lane comes from sel or from an internal round-robin pointer.
module sel1to4_demux_buf #(
   parameter int WIDTH = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [WIDTH-1:0]   din,
   input  logic [1:0]         sel,
   input  logic               auto_sel,
   input  logic               in_valid,
   output logic               in_ready,
   output logic [4*WIDTH-1:0] dout,
   output logic [3:0]         out_valid,
   input  logic [3:0]         out_ready,
   output logic [1:0]         rr_ptr
);

   logic [1:0]         rr_ptr_q, rr_ptr_d;
   logic [3:0]         valid_q, valid_d;
   logic [4*WIDTH-1:0] data_q, data_d;
   logic [1:0]         tgt;
   logic               accept;

   assign tgt      = auto_sel ? rr_ptr_q : sel;
   assign in_ready = !valid_q[tgt] | out_ready[tgt];
   assign accept   = in_valid & in_ready;

   // The pointer only moves on an auto-mode accept, so a full lane stalls rather than being skipped.
   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (accept && auto_sel) begin
         rr_ptr_d = rr_ptr_q + 2'd1;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         logic load;
         assign load = accept && (tgt == gi[1:0]);

         // A reload wins over a drain in the same cycle, keeping the lane at full rate.
         always_comb begin
            valid_d[gi]                = valid_q[gi] & ~out_ready[gi];
            data_d[gi*WIDTH +: WIDTH]  = data_q[gi*WIDTH +: WIDTH];
            if (load) begin
               valid_d[gi]               = 1'b1;
               data_d[gi*WIDTH +: WIDTH] = din;
            end
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr_q <= 2'd0;
         valid_q  <= 4'b0000;
         data_q   <= '0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
         valid_q  <= valid_d;
         data_q   <= data_d;
      end
   end

   assign dout      = data_q;
   assign out_valid = valid_q;
   assign rr_ptr    = rr_ptr_q;

endmodule
